// File: rtl/n64_dd_regs.sv
// N64-side 64DD register front-end: decodes 16-bit PI register accesses and runs the
// command / block-manager request handshakes toward the CPU-side DD service logic.
module n64_dd_regs #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  reg_address,
    input  logic        reg_write,
    input  logic        reg_read,
    input  logic [15:0] reg_wdata,
    output logic [15:0] reg_rdata,
    output logic        reg_ack,
    output logic        irq,
    output logic        hard_reset,
    output logic        cmd_request,
    input  logic        cmd_ack,
    output logic [7:0]  command,
    input  logic [15:0] status,
    output logic [15:0] data_input,
    input  logic [15:0] data_output,
    output logic        bm_request,
    output logic [15:0] bm_control,
    input  logic [15:0] bm_status
);

    // state    | meaning
    // ST_IDLE  | waiting for a read/write strobe
    // ST_ACK   | reg_ack high for one cycle, strobes ignored
    typedef enum logic {ST_IDLE, ST_ACK} bus_state_t;

    localparam logic [2:0] ADDR_DATA  = 3'd0;
    localparam logic [2:0] ADDR_CMD   = 3'd1;
    localparam logic [2:0] ADDR_BM    = 3'd2;
    localparam logic [2:0] ADDR_HRST  = 3'd3;
    localparam logic [2:0] ADDR_LOCAL = 3'd4;

    localparam logic        TIMEOUT_EN = (TIMEOUT_CYCLES != 16'd0);
    localparam logic [15:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 16'd1;

    bus_state_t  state;
    logic        cmd_overrun;
    logic        cmd_timeout;
    logic        bm_timeout;
    logic        bm_busy_seen;
    logic [15:0] cmd_cnt;
    logic [15:0] bm_cnt;
    logic [15:0] rd_mux;

    logic rd_go, wr_go;
    logic wr_data, wr_cmd, wr_bm, wr_hrst, wr_local, rd_local;
    logic cmd_ack_hit, cmd_to_hit, cmd_accept, cmd_drop;
    logic bm_done, bm_to_hit, bm_accept, bm_drop;

    // Read wins over a simultaneous write; nothing is decoded while acking.
    assign rd_go    = (state == ST_IDLE) && reg_read;
    assign wr_go    = (state == ST_IDLE) && reg_write && !reg_read;
    assign wr_data  = wr_go && (reg_address == ADDR_DATA);
    assign wr_cmd   = wr_go && (reg_address == ADDR_CMD);
    assign wr_bm    = wr_go && (reg_address == ADDR_BM);
    assign wr_hrst  = wr_go && (reg_address == ADDR_HRST);
    assign wr_local = wr_go && (reg_address == ADDR_LOCAL);
    assign rd_local = rd_go && (reg_address == ADDR_LOCAL);

    assign cmd_ack_hit = cmd_request && cmd_ack;
    assign cmd_to_hit  = TIMEOUT_EN && cmd_request && (cmd_cnt == TIMEOUT_LAST);
    assign cmd_accept  = wr_cmd && !hard_reset && (!cmd_request || cmd_ack);
    assign cmd_drop    = wr_cmd && !hard_reset && !cmd_accept;

    // The BM channel completes on a busy 1->0 transition seen after the request.
    assign bm_done   = bm_request && bm_busy_seen && !bm_status[15];
    assign bm_to_hit = TIMEOUT_EN && bm_request && (bm_cnt == TIMEOUT_LAST);
    assign bm_accept = wr_bm && !hard_reset && (!bm_request || bm_done);
    assign bm_drop   = wr_bm && !hard_reset && !bm_accept;

    always_comb begin
        rd_mux = 16'h0000;
        case (reg_address)
            ADDR_DATA:  rd_mux = data_output;
            ADDR_CMD:   rd_mux = status;
            ADDR_BM:    rd_mux = bm_status;
            ADDR_HRST:  rd_mux = {15'b0, hard_reset};
            ADDR_LOCAL: rd_mux = {10'b0, bm_timeout, cmd_timeout, irq, cmd_overrun,
                                  bm_request, cmd_request};
            default:    rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            reg_ack   <= 1'b0;
            reg_rdata <= 16'h0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    reg_ack <= 1'b0;
                    if (reg_read || reg_write) begin
                        state   <= ST_ACK;
                        reg_ack <= 1'b1;
                        if (reg_read)
                            reg_rdata <= rd_mux;
                    end
                end
                ST_ACK: begin
                    reg_ack <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    reg_ack <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq          <= 1'b0;
            hard_reset   <= 1'b0;
            cmd_request  <= 1'b0;
            command      <= 8'h00;
            data_input   <= 16'h0000;
            bm_request   <= 1'b0;
            bm_control   <= 16'h0000;
            cmd_overrun  <= 1'b0;
            cmd_timeout  <= 1'b0;
            bm_timeout   <= 1'b0;
            bm_busy_seen <= 1'b0;
            cmd_cnt      <= 16'h0000;
            bm_cnt       <= 16'h0000;
        end else begin
            if (wr_data)
                data_input <= reg_wdata;
            if (wr_hrst)
                hard_reset <= reg_wdata[0];

            // Reading LOCAL clears the sticky flags; new events this cycle still land.
            if (rd_local) begin
                cmd_overrun <= 1'b0;
                cmd_timeout <= 1'b0;
                bm_timeout  <= 1'b0;
            end
            if (cmd_drop || bm_drop)
                cmd_overrun <= 1'b1;

            if (hard_reset) begin
                cmd_request <= 1'b0;
                bm_request  <= 1'b0;
                irq         <= 1'b0;
            end else begin
                if (cmd_accept) begin
                    command     <= reg_wdata[7:0];
                    cmd_request <= 1'b1;
                    cmd_cnt     <= 16'h0000;
                end else if (cmd_ack_hit) begin
                    cmd_request <= 1'b0;
                end else if (cmd_to_hit) begin
                    cmd_request <= 1'b0;
                    cmd_timeout <= 1'b1;
                end else if (cmd_request) begin
                    cmd_cnt <= cmd_cnt + 16'd1;
                end

                if (cmd_ack_hit)
                    irq <= 1'b1;
                else if (wr_local && reg_wdata[3])
                    irq <= 1'b0;

                if (bm_accept) begin
                    bm_control   <= reg_wdata;
                    bm_request   <= 1'b1;
                    bm_cnt       <= 16'h0000;
                    bm_busy_seen <= 1'b0;
                end else if (bm_done) begin
                    bm_request <= 1'b0;
                end else if (bm_to_hit) begin
                    bm_request <= 1'b0;
                    bm_timeout <= 1'b1;
                end else if (bm_request) begin
                    bm_cnt <= bm_cnt + 16'd1;
                    if (bm_status[15])
                        bm_busy_seen <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_n64_dd_regs.sv
// Directed bench for n64_dd_regs: table-driven register map sweep plus hand-written
// sequences for the command / block-manager handshakes, timeouts and hard reset.
module tb_n64_dd_regs;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  reg_address = 3'd0;
    logic        reg_write = 1'b0;
    logic        reg_read = 1'b0;
    logic [15:0] reg_wdata = 16'h0000;
    logic [15:0] reg_rdata;
    logic        reg_ack;
    logic        irq;
    logic        hard_reset;
    logic        cmd_request;
    logic        cmd_ack = 1'b0;
    logic [7:0]  command;
    logic [15:0] status = 16'h0000;
    logic [15:0] data_input;
    logic [15:0] data_output = 16'h0000;
    logic        bm_request;
    logic [15:0] bm_control;
    logic [15:0] bm_status = 16'h0000;

    int n_checks = 0;
    int n_fail = 0;

    n64_dd_regs #(.TIMEOUT_CYCLES(16'd8)) dut (
        .clk(clk), .reset_n(reset_n),
        .reg_address(reg_address), .reg_write(reg_write), .reg_read(reg_read),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
        .irq(irq), .hard_reset(hard_reset),
        .cmd_request(cmd_request), .cmd_ack(cmd_ack), .command(command),
        .status(status), .data_input(data_input), .data_output(data_output),
        .bm_request(bm_request), .bm_control(bm_control), .bm_status(bm_status)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic access(input logic rd, input logic wr, input logic [2:0] a,
                          input logic [15:0] d, input logic cack);
        reg_read    = rd;
        reg_write   = wr;
        reg_address = a;
        reg_wdata   = d;
        cmd_ack     = cack;
        tick(1);
        reg_read  = 1'b0;
        reg_write = 1'b0;
        cmd_ack   = 1'b0;
        check("ack_high", reg_ack, 16'd1);
        tick(1);
        check("ack_low", reg_ack, 16'd0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        access(1'b0, 1'b1, a, d, 1'b0);
    endtask

    task automatic rd(input string name, input logic [2:0] a, input logic [15:0] exp);
        access(1'b1, 1'b0, a, 16'h0000, 1'b0);
        check(name, reg_rdata, exp);
    endtask

    task automatic pulse_ack();
        cmd_ack = 1'b1;
        tick(1);
        cmd_ack = 1'b0;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic [15:0] exp_din;
    } vec_t;

    vec_t vecs[17];

    initial begin
        int n;

        vecs[0]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 16'h1234, 16'h0000};
        vecs[1]  = '{1'b0, 1'b1, 3'd0, 16'hCAFE, 16'h1234, 16'hCAFE};
        vecs[2]  = '{1'b1, 1'b0, 3'd1, 16'h0000, 16'hA5A5, 16'hCAFE};
        vecs[3]  = '{1'b1, 1'b0, 3'd2, 16'h0000, 16'h0F0F, 16'hCAFE};
        vecs[4]  = '{1'b1, 1'b0, 3'd3, 16'h0000, 16'h0000, 16'hCAFE};
        vecs[5]  = '{1'b1, 1'b0, 3'd1, 16'h0000, 16'hA5A5, 16'hCAFE};
        vecs[6]  = '{1'b1, 1'b0, 3'd4, 16'h0000, 16'h0000, 16'hCAFE};
        vecs[7]  = '{1'b0, 1'b1, 3'd5, 16'hFFFF, 16'h0000, 16'hCAFE};
        vecs[8]  = '{1'b1, 1'b0, 3'd1, 16'h0000, 16'hA5A5, 16'hCAFE};
        vecs[9]  = '{1'b1, 1'b0, 3'd5, 16'h0000, 16'h0000, 16'hCAFE};
        vecs[10] = '{1'b0, 1'b1, 3'd6, 16'hFFFF, 16'h0000, 16'hCAFE};
        vecs[11] = '{1'b1, 1'b0, 3'd1, 16'h0000, 16'hA5A5, 16'hCAFE};
        vecs[12] = '{1'b1, 1'b0, 3'd6, 16'h0000, 16'h0000, 16'hCAFE};
        vecs[13] = '{1'b0, 1'b1, 3'd7, 16'hFFFF, 16'h0000, 16'hCAFE};
        vecs[14] = '{1'b1, 1'b0, 3'd1, 16'h0000, 16'hA5A5, 16'hCAFE};
        vecs[15] = '{1'b1, 1'b0, 3'd7, 16'h0000, 16'h0000, 16'hCAFE};
        vecs[16] = '{1'b1, 1'b1, 3'd0, 16'hBBBB, 16'h1234, 16'hCAFE};

        // Reset state
        tick(2);
        check("rst_ack", reg_ack, 16'd0);
        check("rst_rdata", reg_rdata, 16'h0000);
        check("rst_irq", irq, 16'd0);
        check("rst_hard_reset", hard_reset, 16'd0);
        check("rst_cmd_request", cmd_request, 16'd0);
        check("rst_command", command, 16'h0000);
        check("rst_data_input", data_input, 16'h0000);
        check("rst_bm_request", bm_request, 16'd0);
        check("rst_bm_control", bm_control, 16'h0000);
        reset_n = 1'b1;
        status      = 16'hA5A5;
        data_output = 16'h1234;
        bm_status   = 16'h0F0F;
        tick(1);

        // Register map sweep
        for (int i = 0; i < 17; i++) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0);
            check($sformatf("vec%0d_rdata", i), reg_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_din", i), data_input, vecs[i].exp_din);
            check($sformatf("vec%0d_reqs", i), {13'b0, hard_reset, bm_request, cmd_request}, 16'h0000);
        end
        bm_status = 16'h0000;

        // Strobe held into the ACK cycle is ignored
        reg_write = 1'b1; reg_address = 3'd0; reg_wdata = 16'h1111;
        tick(1);
        check("hold_ack_high", reg_ack, 16'd1);
        reg_wdata = 16'h2222;
        tick(1);
        reg_write = 1'b0;
        check("hold_ack_low", reg_ack, 16'd0);
        check("hold_din", data_input, 16'h1111);
        tick(1);
        check("hold_no_reack", reg_ack, 16'd0);

        // Command accepted, acked later, irq raised
        wr(3'd1, 16'h0021);
        check("cmd1_command", command, 16'h0021);
        check("cmd1_req", cmd_request, 16'd1);
        tick(2);
        check("cmd1_req_held", cmd_request, 16'd1);
        check("cmd1_irq_pre", irq, 16'd0);
        pulse_ack();
        check("cmd1_req_clr", cmd_request, 16'd0);
        check("cmd1_irq", irq, 16'd1);
        rd("cmd1_local", 3'd4, 16'h0008);

        // Overrun on second command, then timeout of the pending one
        wr(3'd4, 16'h0008);
        check("irq_clr", irq, 16'd0);
        wr(3'd1, 16'h0021);
        wr(3'd1, 16'h0022);
        check("ovr_command", command, 16'h0021);
        rd("ovr_local1", 3'd4, 16'h0005);
        rd("ovr_local2", 3'd4, 16'h0001);
        tick(3);
        check("ovr_req_to", cmd_request, 16'd0);
        rd("ovr_local3", 3'd4, 16'h0010);
        rd("ovr_local4", 3'd4, 16'h0000);

        // Timeout: request high for exactly 8 cycles
        reg_write = 1'b1; reg_address = 3'd1; reg_wdata = 16'h0025;
        tick(1);
        reg_write = 1'b0;
        n = 0;
        while (cmd_request && n < 20) begin
            n++;
            tick(1);
        end
        check("to_cycles", n[15:0], 16'd8);
        check("to_command", command, 16'h0025);
        rd("to_local", 3'd4, 16'h0010);
        rd("to_local_clr", 3'd4, 16'h0000);

        // CMD write coincident with cmd_ack, then irq set beats clear
        wr(3'd1, 16'h002F);
        access(1'b0, 1'b1, 3'd1, 16'h0030, 1'b1);
        check("same_command", command, 16'h0030);
        check("same_req", cmd_request, 16'd1);
        check("same_irq", irq, 16'd1);
        wr(3'd4, 16'h0008);
        access(1'b0, 1'b1, 3'd4, 16'h0008, 1'b1);
        check("setwins_irq", irq, 16'd1);
        check("setwins_req", cmd_request, 16'd0);
        rd("setwins_local", 3'd4, 16'h0008);
        wr(3'd4, 16'h0008);
        check("setwins_irq_clr", irq, 16'd0);

        // Hard reset
        wr(3'd1, 16'h0040);
        pulse_ack();
        wr(3'd1, 16'h0041);
        check("hr_irq_pre", irq, 16'd1);
        wr(3'd3, 16'h0001);
        check("hr_level", hard_reset, 16'd1);
        check("hr_req", cmd_request, 16'd0);
        check("hr_irq", irq, 16'd0);
        rd("hr_read3", 3'd3, 16'h0001);
        wr(3'd1, 16'h0050);
        check("hr_cmd_drop", command, 16'h0041);
        check("hr_cmd_req", cmd_request, 16'd0);
        wr(3'd0, 16'h1234);
        check("hr_data", data_input, 16'h1234);
        rd("hr_local", 3'd4, 16'h0000);
        wr(3'd3, 16'h0000);
        check("hr_release", hard_reset, 16'd0);
        wr(3'd1, 16'h0050);
        check("hr_cmd_again", command, 16'h0050);
        check("hr_req_again", cmd_request, 16'd1);
        pulse_ack();
        wr(3'd4, 16'h0008);

        // Block manager: busy 1->0 completes, cmd_ack has no effect
        wr(3'd2, 16'hBEEF);
        check("bm_control", bm_control, 16'hBEEF);
        check("bm_req", bm_request, 16'd1);
        pulse_ack();
        check("bm_req_cmdack", bm_request, 16'd1);
        check("bm_irq_cmdack", irq, 16'd0);
        bm_status = 16'h8000;
        tick(1);
        check("bm_req_busy", bm_request, 16'd1);
        bm_status = 16'h0000;
        tick(1);
        check("bm_req_done", bm_request, 16'd0);
        check("bm_irq", irq, 16'd0);

        // Block manager overrun and timeout
        wr(3'd2, 16'h1111);
        wr(3'd2, 16'h2222);
        check("bm_ovr_control", bm_control, 16'h1111);
        rd("bm_ovr_local", 3'd4, 16'h0006);
        tick(4);
        check("bm_to_req", bm_request, 16'd0);
        rd("bm_to_local", 3'd4, 16'h0020);
        rd("bm_to_local_clr", 3'd4, 16'h0000);

        // Async reset during an access
        wr(3'd1, 16'h0060);
        reg_read = 1'b1; reg_address = 3'd1;
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_req", cmd_request, 16'd0);
        check("arst_command", command, 16'h0000);
        @(posedge clk);
        #1;
        reg_read = 1'b0;
        check("arst_no_ack", reg_ack, 16'd0);
        tick(1);
        check("arst_no_ack2", reg_ack, 16'd0);
        reset_n = 1'b1;
        tick(1);
        rd("arst_after", 3'd1, 16'hA5A5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
